// File: rtl/anton_neopixel_feeder.sv
// Pixel-stream to byte-bus feeder: unpacks 24/32-bit pixels into sequential buffer writes,
// then closes each frame with reg_max low/high and control-register writes.
module anton_neopixel_feeder #(
   parameter int unsigned BUFFER_END = 8191,
   parameter logic [13:0] MAX_ADDR   = 14'h2000,
   parameter logic [13:0] CTRL_ADDR  = 14'h2002,
   parameter logic [7:0]  CTRL_START = 8'h05
) (
   input  logic        busClk,
   input  logic        busResetN,
   input  logic        pixValid,
   output logic        pixReady,
   input  logic [31:0] pixData,
   input  logic        pixLast,
   input  logic        mode32,
   output logic [13:0] busAddr,
   output logic [7:0]  busData,
   output logic        busWrite,
   output logic        frameDone,
   output logic        overflow
);

   typedef enum logic [2:0] {IDLE, BYTES, MAX_LO, MAX_HI, CTRL} state_t;

   state_t      state_q, state_d;
   logic [31:0] data_q, data_d;
   logic        last_q, last_d;
   logic        mode32_q, mode32_d;
   logic        first_q, first_d;
   logic [1:0]  idx_q, idx_d;
   logic [13:0] addr_q, addr_d;
   logic [12:0] count_q, count_d;
   logic        overflow_q, overflow_d;

   logic        in_range;
   logic        last_byte;
   logic [12:0] count_m1;
   logic [7:0]  cur_byte;

   assign in_range  = ({18'd0, addr_q} <= BUFFER_END);
   assign last_byte = (idx_q == (mode32_q ? 2'd3 : 2'd2));
   assign count_m1  = count_q - 13'd1;
   assign overflow  = overflow_q;

   always_comb begin
      case (idx_q)
         2'd0:    cur_byte = data_q[7:0];
         2'd1:    cur_byte = data_q[15:8];
         2'd2:    cur_byte = data_q[23:16];
         default: cur_byte = data_q[31:24];
      endcase
   end

   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      last_d     = last_q;
      mode32_d   = mode32_q;
      first_d    = first_q;
      idx_d      = idx_q;
      addr_d     = addr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      pixReady   = 1'b0;
      busAddr    = 14'd0;
      busData    = 8'd0;
      busWrite   = 1'b0;
      frameDone  = 1'b0;

      case (state_q)
         IDLE: begin
            // Ready is gated by reset so nothing upstream sees a handshake while held.
            pixReady = busResetN;
            if (pixValid && busResetN) begin
               data_d  = pixData;
               last_d  = pixLast;
               idx_d   = 2'd0;
               state_d = BYTES;
               if (first_q) begin
                  mode32_d   = mode32;
                  addr_d     = 14'd0;
                  count_d    = 13'd0;
                  overflow_d = 1'b0;
                  first_d    = 1'b0;
               end
            end
         end
         BYTES: begin
            busAddr  = addr_q;
            busData  = cur_byte;
            busWrite = in_range;
            if (!in_range) overflow_d = 1'b1;
            // Saturate rather than wrap so out-of-range bytes never hit low addresses.
            addr_d = (addr_q == 14'h3FFF) ? addr_q : addr_q + 14'd1;
            if (last_byte) begin
               idx_d   = 2'd0;
               count_d = (count_q == 13'h1FFF) ? count_q : count_q + 13'd1;
               state_d = last_q ? MAX_LO : IDLE;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         MAX_LO: begin
            busAddr  = MAX_ADDR;
            busData  = count_m1[7:0];
            busWrite = 1'b1;
            state_d  = MAX_HI;
         end
         MAX_HI: begin
            busAddr  = MAX_ADDR + 14'd1;
            busData  = {3'b000, count_m1[12:8]};
            busWrite = 1'b1;
            state_d  = CTRL;
         end
         CTRL: begin
            busAddr   = CTRL_ADDR;
            busData   = CTRL_START;
            busWrite  = 1'b1;
            frameDone = 1'b1;
            first_d   = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge busClk or negedge busResetN) begin
      if (!busResetN) begin
         state_q    <= IDLE;
         data_q     <= 32'd0;
         last_q     <= 1'b0;
         mode32_q   <= 1'b0;
         first_q    <= 1'b1;
         idx_q      <= 2'd0;
         addr_q     <= 14'd0;
         count_q    <= 13'd0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         last_q     <= last_d;
         mode32_q   <= mode32_d;
         first_q    <= first_d;
         idx_q      <= idx_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_anton_neopixel_feeder.sv
// Bench for anton_neopixel_feeder: two instances (full buffer and BUFFER_END=5) share stimulus;
// a per-cycle expectation queue built from the frame rules is checked every cycle.
module tb_anton_neopixel_feeder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pix_valid = 1'b0;
   logic [31:0] pix_data = 32'd0;
   logic        pix_last = 1'b0;
   logic        mode32 = 1'b0;

   logic        rdy  [2];
   logic [13:0] addr [2];
   logic [7:0]  data [2];
   logic        we   [2];
   logic        fd   [2];
   logic        ovf  [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   anton_neopixel_feeder dut_a (
      .busClk(clk), .busResetN(rst_n), .pixValid(pix_valid), .pixReady(rdy[0]),
      .pixData(pix_data), .pixLast(pix_last), .mode32(mode32), .busAddr(addr[0]),
      .busData(data[0]), .busWrite(we[0]), .frameDone(fd[0]), .overflow(ovf[0]));

   anton_neopixel_feeder #(.BUFFER_END(5)) dut_b (
      .busClk(clk), .busResetN(rst_n), .pixValid(pix_valid), .pixReady(rdy[1]),
      .pixData(pix_data), .pixLast(pix_last), .mode32(mode32), .busAddr(addr[1]),
      .busData(data[1]), .busWrite(we[1]), .frameDone(fd[1]), .overflow(ovf[1]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: each accepted pixel expands into a list of expected bus cycles.
   typedef struct {
      logic [1:0]  wr;
      logic [13:0] a;
      logic [7:0]  d;
      logic        done;
   } rec_t;

   rec_t        exp_q[$];
   int unsigned bend [2] = '{8191, 5};
   logic        m_first = 1'b1;
   logic        m_mode = 1'b0;
   logic [13:0] m_addr = 14'd0;
   logic [12:0] m_cnt = 13'd0;
   logic        exp_ovf [2] = '{1'b0, 1'b0};
   logic [21:0] log_a[$];
   logic [21:0] log_b[$];
   int          fd_cnt = 0;

   task automatic model_accept(input logic [31:0] d, input logic l, input logic m);
      rec_t r;
      logic [12:0] m1;
      if (m_first) begin
         m_mode  = m;
         m_addr  = 14'd0;
         m_cnt   = 13'd0;
         m_first = 1'b0;
         exp_ovf[0] = 1'b0;
         exp_ovf[1] = 1'b0;
      end
      $display("pixel data=%h last=%0d mode32=%0d first_addr=%0d", d, l, m_mode, m_addr);
      for (int k = 0; k < (m_mode ? 4 : 3); k++) begin
         r.a = m_addr;
         r.d = d[8*k +: 8];
         r.done = 1'b0;
         for (int i = 0; i < 2; i++) r.wr[i] = (int'(m_addr) <= int'(bend[i]));
         exp_q.push_back(r);
         if (m_addr != 14'h3FFF) m_addr = m_addr + 14'd1;
      end
      if (m_cnt != 13'h1FFF) m_cnt = m_cnt + 13'd1;
      if (l) begin
         m1 = m_cnt - 13'd1;
         r.wr = 2'b11;
         r.a = 14'h2000; r.d = m1[7:0];           r.done = 1'b0; exp_q.push_back(r);
         r.a = 14'h2001; r.d = {3'b000, m1[12:8]}; r.done = 1'b0; exp_q.push_back(r);
         r.a = 14'h2002; r.d = 8'h05;             r.done = 1'b1; exp_q.push_back(r);
         m_first = 1'b1;
      end
   endtask

   // Inputs change only just after posedge, so sampling at negedge equals sampling at the edge.
   always @(negedge clk) begin
      rec_t r;
      logic ready_now;
      ready_now = 1'b0;
      if (!rst_n) begin
         exp_q.delete();
         m_first = 1'b1;
         exp_ovf[0] = 1'b0;
         exp_ovf[1] = 1'b0;
         for (int i = 0; i < 2; i++) begin
            chk("rst_write", {31'd0, we[i]}, 32'd0);
            chk("rst_addr", {18'd0, addr[i]}, 32'd0);
            chk("rst_data", {24'd0, data[i]}, 32'd0);
            chk("rst_done", {31'd0, fd[i]}, 32'd0);
            chk("rst_ready", {31'd0, rdy[i]}, 32'd0);
            chk("rst_ovf", {31'd0, ovf[i]}, 32'd0);
         end
      end else if (exp_q.size() > 0) begin
         r = exp_q.pop_front();
         for (int i = 0; i < 2; i++) begin
            chk("busy_write", {31'd0, we[i]}, {31'd0, r.wr[i]});
            if (r.wr[i]) begin
               chk("busy_addr", {18'd0, addr[i]}, {18'd0, r.a});
               chk("busy_data", {24'd0, data[i]}, {24'd0, r.d});
            end
            chk("busy_done", {31'd0, fd[i]}, {31'd0, r.done});
            chk("busy_ready", {31'd0, rdy[i]}, 32'd0);
            chk("busy_ovf", {31'd0, ovf[i]}, {31'd0, exp_ovf[i]});
            if (!r.wr[i]) exp_ovf[i] = 1'b1;
         end
      end else begin
         ready_now = 1'b1;
         for (int i = 0; i < 2; i++) begin
            chk("idle_write", {31'd0, we[i]}, 32'd0);
            chk("idle_done", {31'd0, fd[i]}, 32'd0);
            chk("idle_ready", {31'd0, rdy[i]}, 32'd1);
            chk("idle_ovf", {31'd0, ovf[i]}, {31'd0, exp_ovf[i]});
         end
      end
      if (we[0] === 1'b1) log_a.push_back({addr[0], data[0]});
      if (we[1] === 1'b1) log_b.push_back({addr[1], data[1]});
      if (fd[0] === 1'b1) fd_cnt++;
      if (ready_now && rst_n && pix_valid) model_accept(pix_data, pix_last, mode32);
   end

   task automatic send(input logic [31:0] d, input logic l, input logic m);
      int n;
      n = 0;
      pix_valid = 1'b1; pix_data = d; pix_last = l; mode32 = m;
      @(negedge clk);
      while (rdy[0] !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL handshake_timeout actual=no_ready expected=ready t=%0t", $time);
      end
      @(posedge clk); #1;
   endtask

   task automatic drop();
      pix_valid = 1'b0;
      pix_data  = $urandom;
      pix_last  = 1'($urandom);
      mode32    = 1'($urandom);
   endtask

   task automatic settle();
      repeat (12) @(posedge clk);
      #1;
   endtask

   initial begin
      int s;
      int f;
      logic [21:0] t1_lit [6];
      t1_lit = '{{14'h0000, 8'hC3}, {14'h0001, 8'hB2}, {14'h0002, 8'hA1},
                 {14'h2000, 8'h00}, {14'h2001, 8'h00}, {14'h2002, 8'h05}};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Single 24-bit pixel frame
      s = log_a.size(); f = fd_cnt;
      send(32'h00A1B2C3, 1'b1, 1'b0); drop(); settle();
      chk("t1_count", log_a.size() - s, 6);
      for (int i = 0; i < 6; i++) chk("t1_write", {10'd0, log_a[s+i]}, {10'd0, t1_lit[i]});
      chk("t1_frame_done", fd_cnt - f, 1);

      // Three 32-bit pixels
      s = log_a.size();
      send(32'h11223344, 1'b0, 1'b1);
      send(32'h55667788, 1'b0, 1'b1);
      send(32'h99AABBCC, 1'b1, 1'b1); drop(); settle();
      chk("t2_count", log_a.size() - s, 15);
      chk("t2_first", {10'd0, log_a[s]}, {10'd0, 14'd0, 8'h44});
      chk("t2_byte11", {10'd0, log_a[s+11]}, {10'd0, 14'd11, 8'h99});
      chk("t2_max_lo", {10'd0, log_a[s+12]}, {10'd0, 14'h2000, 8'h02});

      // Overflow on the small-buffer instance
      s = log_b.size();
      send(32'h00030201, 1'b0, 1'b0);
      send(32'h00060504, 1'b0, 1'b0);
      send(32'h00090807, 1'b1, 1'b0); drop(); settle();
      chk("t3_count_b", log_b.size() - s, 9);
      chk("t3_addr5_b", {10'd0, log_b[s+5]}, {10'd0, 14'd5, 8'h06});
      chk("t3_max_lo_b", {10'd0, log_b[s+6]}, {10'd0, 14'h2000, 8'h02});
      chk("t3_ovf_b", {31'd0, ovf[1]}, 32'd1);
      chk("t3_ovf_a", {31'd0, ovf[0]}, 32'd0);

      // mode32 changed mid-frame is ignored; overflow clears on first accept
      s = log_a.size();
      send(32'h00C0B0A0, 1'b0, 1'b0);
      chk("t4_ovf_cleared_b", {31'd0, ovf[1]}, 32'd0);
      send(32'hFFF3F2F1, 1'b0, 1'b1);
      send(32'hEEE6E5E4, 1'b1, 1'b1); drop(); settle();
      chk("t4_count", log_a.size() - s, 12);
      chk("t4_byte8", {10'd0, log_a[s+8]}, {10'd0, 14'd8, 8'hE6});
      chk("t4_max_lo", {10'd0, log_a[s+9]}, {10'd0, 14'h2000, 8'h02});

      // Reset during the second pixel's bytes
      s = log_a.size(); f = fd_cnt;
      send(32'h00332211, 1'b0, 1'b0);
      send(32'h00665544, 1'b1, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0; drop();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("t5_count", log_a.size() - s, 4);
      chk("t5_last_before_rst", {10'd0, log_a[s+3]}, {10'd0, 14'd3, 8'h44});
      chk("t5_no_frame_done", fd_cnt - f, 0);
      s = log_a.size();
      send(32'h00787776, 1'b1, 1'b0); drop(); settle();
      chk("t5_restart", {10'd0, log_a[s]}, {10'd0, 14'd0, 8'h76});

      // Two single-pixel frames back to back
      s = log_a.size(); f = fd_cnt;
      send(32'h000A0B0C, 1'b1, 1'b0);
      send(32'h1D2D3D4D, 1'b1, 1'b1); drop(); settle();
      chk("t6_count", log_a.size() - s, 13);
      chk("t6_second_start", {10'd0, log_a[s+6]}, {10'd0, 14'd0, 8'h4D});
      chk("t6_frame_done", fd_cnt - f, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
